pwm_capture: RTL
================

Name: pwm_capture

Overview:
- PWM receiver/decoder. Recovers the duty word from a PWM stream: 2-bit stream, bit0 pulse, bit1 sign.
- The stream uses the team's standard PWM encoding.
  - Counter width M = N-gtype, period P = 2^M clocks.
  - Unsigned mode (gtype=0): high-time h = in.
  - Signed mode (gtype=1):
    - sign=0: h = in[N-2:0].
    - sign=1: h = 2^M - in[N-2:0]. in[N-2:0]=0 with sign=1 gives 100% duty.
- Used for loopback checking of PWM outputs and for decoding PWM commands arriving from off-board.

Parameters:
- N, 8: width of the decoded value.
- gtype, 0: 0 = unsigned stream; 1 = signed stream, pwm_in[1] carries the sign.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- pwm_in, input, 2: [0] pulse, [1] sign (ignored when gtype=0). Asynchronous to clk.
- value, output, N: last decoded duty word.
- valid, output, 1: one-cycle strobe; value and err are updated on this cycle.
- err, output, 1: the period just decoded had length ≠ P. Qualified by valid.

Behaviour:
- Reset values: value=0, valid=0, err=0. Internal state IDLE, counters 0.
- Reset mid-measurement: the partial period is discarded and no valid is issued. The next rising edge only re-arms.
- Input conditioning: both bits pass a 2-flop synchronizer. Rising edge = (p_sync==1 && p_prev==0).
- Counters:
  - per_cnt (M+1 bits): clocks since the last rising edge; saturates at all-ones.
  - hi_cnt (M+1 bits): clocks with p_sync=1 since the last rising edge; saturates.
  - Both counters load 1 or 0 on a rising edge, according to the current level.
- sgn_lat: captures s_sync on each rising edge.
- State IDLE:
  - Rising edge → MEAS, counters restart, no valid.
  - per_cnt reaching 2P → STATIC.
- State MEAS:
  - A rising edge closes the period: value decoded from (hi_cnt, sgn_lat); valid=1 on the next cycle; err = (per_cnt ≠ P).
  - Counters restart in the same cycle.
  - No edge for 2P clocks → STATIC.
- State STATIC (steady level):
  - On entry and then every P clocks: valid=1, err=0, value set by level:
    - p_sync=0 → 0.
    - p_sync=1, gtype=0 → all-ones.
    - p_sync=1, gtype=1, sign=1 → {1, 0…0} (most negative).
    - p_sync=1, gtype=1, sign=0 → {0, 1…1}.
  - Rising edge → MEAS; the first period after STATIC produces no valid.
- Decode rules:
  - gtype=0: value = min(hi_cnt, 2^N-1).
  - gtype=1, sign=0: value = {0, min(hi_cnt, 2^M-1)}.
  - gtype=1, sign=1: value = {1, (2^M - hi_cnt)[M-1:0]}. hi_cnt=2^M gives {1, 0…0}; hi_cnt=0 gives {1, 0…0}.
  - All arithmetic is in M+1 bits; the result is truncated to M bits.
- Simultaneous events: a rising edge in the same cycle as the 2P timeout → edge wins and the state stays MEAS.
- Latency: pin edge to valid is 4 clocks (2 sync, 1 edge detect, 1 output register). Plus 1 clock when the filter below is enabled.
- value holds between valid strobes; valid is never high on two consecutive cycles.

Optional Feature:
- Macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - A 3-tap majority filter follows the synchronizer on both bits; single-cycle glitches are rejected.
  - All edges are delayed by a uniform 1 clock, so hi_cnt and per_cnt are unchanged for clean streams.
- Undefined: the filter is absent; latency is 4 clocks; single-cycle glitches are counted as pulses and appear as err=1 or a wrong value.

Test Plan:
- N=8, gtype=0, stream from the standard encoder with in=64 → after the first re-arm period, valid every 256 clocks with value=64, err=0.
- N=8, gtype=1, in=0xC0 (64 high clocks per 128, sign=1) → value=0xC0, err=0. Then in=0x25 (sign=0) → value=0x25 by the second period after the change.
- gtype=0, constant low, after reset → first valid at per_cnt=512 with value=0x00, then every 256 clocks. gtype=1, constant high with sign=1 → value=0x80.
- gtype=0, 40 clocks high in a 200-clock period → value=40, err=1. Then a clean 256-clock period → err=0.
- Reset asserted for 3 clocks at mid-period → outputs 0 immediately; no valid until one full period after the next rising edge.
- Filter enabled: a 1-clock low glitch inside a 100-clock high pulse → value=100, err=0. Filter disabled: err=1 on the affected period.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: decodes a PWM stream (bit0 pulse, bit1 sign) back into its duty word.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-tap majority filter after the synchronizer.
module pwm_capture #(
  parameter int N     = 8,
  parameter int gtype = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   pwm_in,
  output logic [N-1:0] value,
  output logic         valid,
  output logic         err
);
  localparam int M = N - gtype;
  localparam logic [M:0] PER = {1'b1, {M{1'b0}}};
  typedef enum logic [1:0] {IDLE, MEAS, STATIC} state_t;
  state_t st_q, st_d;
  logic [1:0] s1_q, s2_q, cond, p_q;
  logic pp_q, sgn_q, sgn_d, vld_q, vld_d, err_q, err_d, rise, tmo, sgn_m;
  logic [M:0] per_q, per_d, hi_q, hi_d;
  logic [M-1:0] min_m;
  logic [N-1:0] val_q, val_d, dec, stat;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] d1_q, d2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      d1_q <= s2_q;
      d2_q <= d1_q;
    end
  // majority of three consecutive samples: clean edges pass one clock late, 1-clock pulses vanish
  assign cond = (s2_q & d1_q) | (s2_q & d2_q) | (d1_q & d2_q);
`else
  assign cond = s2_q;
`endif
  assign rise  = p_q[0] & ~pp_q;
  assign tmo   = &per_q;
  assign min_m = hi_q[M] ? '1 : hi_q[M-1:0];
  assign sgn_m = (gtype != 0) && sgn_q;
  // negative words carry 2^M - hi_cnt, truncated to M bits
  assign dec   = sgn_m ? {1'b1, (N-1)'(-hi_q[M-1:0])} : N'(min_m);
  assign stat  = !p_q[0] ? '0 : (gtype == 0) ? '1 :
                 p_q[1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  always_comb begin
    st_d  = st_q;
    per_d = tmo ? per_q : per_q + 1'b1;
    hi_d  = (p_q[0] && !(&hi_q)) ? hi_q + 1'b1 : hi_q;
    sgn_d = sgn_q;
    val_d = val_q;
    vld_d = 1'b0;
    err_d = err_q;
    if (rise) begin
      st_d  = MEAS;
      per_d = {{M{1'b0}}, 1'b1};
      hi_d  = {{M{1'b0}}, p_q[0]};
      sgn_d = p_q[1];
      if (st_q == MEAS) begin
        vld_d = 1'b1;
        val_d = dec;
        err_d = per_q != PER;
      end
    end else if (st_q == STATIC ? per_q == PER : tmo) begin
      st_d  = STATIC;
      per_d = {{M{1'b0}}, 1'b1};
      vld_d = 1'b1;
      val_d = stat;
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      p_q   <= '0;
      pp_q  <= 1'b0;
      st_q  <= IDLE;
      per_q <= '0;
      hi_q  <= '0;
      sgn_q <= 1'b0;
      val_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q  <= pwm_in;
      s2_q  <= s1_q;
      p_q   <= cond;
      pp_q  <= p_q[0];
      st_q  <= st_d;
      per_q <= per_d;
      hi_q  <= hi_d;
      sgn_q <= sgn_d;
      val_q <= val_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  assign value = val_q;
  assign valid = vld_q;
  assign err   = err_q;
endmodule
